// File: rtl/spi_slave.sv
// SPI responder: oversamples sck/cs_n/mosi in the clk domain. MOSI words go out on an
// AXI-stream source and AXI-stream sink words are shifted onto MISO. Supports CPOL/CPHA 0..3.
module spi_slave #(
    parameter int unsigned                TRANSFER_WIDTH = 8,
    parameter bit                         CPOL           = 1'b0,
    parameter bit                         CPHA           = 1'b0,
    parameter logic [TRANSFER_WIDTH-1:0]  IDLE_WORD      = {TRANSFER_WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sck,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    input  logic [TRANSFER_WIDTH-1:0] tx_tdata,
    input  logic                      tx_tvalid,
    output logic                      tx_tready,
    output logic [TRANSFER_WIDTH-1:0] rx_tdata,
    output logic                      rx_tvalid,
    input  logic                      rx_tready,
    output logic                      tx_underrun,
    output logic                      rx_overrun,
    output logic                      frame_abort
);
    localparam int unsigned W     = TRANSFER_WIDTH;
    localparam int unsigned CNT_W = $clog2(TRANSFER_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TRANSFER_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACTIVE} state_t;

    state_t           state;
    logic [1:0]       sck_sync, cs_sync, mosi_sync;
    logic             sck_prev;
    logic [W-1:0]     tx_shift, rx_shift;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;

    logic             sck_s, cs_s, mosi_s;
    logic             leading_c, trailing_c, sample_c, update_c;
    logic             reload_c, load_c;
    logic [W-1:0]     load_word_c;

    assign sck_s  = sck_sync[1];
    assign cs_s   = cs_sync[1];
    assign mosi_s = mosi_sync[1];

    assign leading_c  = (sck_s != sck_prev) && (sck_prev == CPOL);
    assign trailing_c = (sck_s != sck_prev) && (sck_s == CPOL);
    assign sample_c   = CPHA ? trailing_c : leading_c;
    assign update_c   = CPHA ? leading_c  : trailing_c;

    // Word (re)load: frame start, or the end-of-word edge for back-to-back words
    assign load_word_c = tx_tvalid ? tx_tdata : IDLE_WORD;
    assign reload_c    = (state == ST_ACTIVE) && !cs_s &&
                         (CPHA ? (sample_c && (bit_cnt == LAST))
                               : (update_c && (bit_cnt == '0)));
    assign load_c      = (state == ST_LOAD) || reload_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= {2{CPOL}};
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sck_prev    <= CPOL;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_tready   <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            rx_tvalid   <= 1'b0;
            rx_tdata    <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
        end else begin
            tx_tready   <= load_c && tx_tvalid;
            tx_underrun <= load_c && !tx_tvalid;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            word_done   <= 1'b0;

            // Hold the edge detector across the cs fall and LOAD so an early edge lands in ACTIVE
            if ((state == ST_ACTIVE) || ((state == ST_IDLE) && cs_s))
                sck_prev <= sck_s;

            if (word_done) begin
                if (rx_tvalid && !rx_tready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_tdata  <= rx_shift;
                    rx_tvalid <= 1'b1;
                end
            end else if (rx_tvalid && rx_tready) begin
                rx_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!cs_s)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_shift <= load_word_c;
                    miso_oe  <= 1'b1;
                    if (!CPHA)
                        miso <= load_word_c[W-1];
                    state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cs_s) begin
                        state   <= ST_IDLE;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0)
                            frame_abort <= 1'b1;
                    end else begin
                        if (sample_c) begin
                            rx_shift <= {rx_shift[W-2:0], mosi_s};
                            if (bit_cnt == LAST) begin
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (load_c)
                            tx_shift <= load_word_c;
                        else if (update_c && !(CPHA && (bit_cnt == '0)))
                            tx_shift <= tx_shift << 1;
                        if (update_c) begin
                            if (bit_cnt == '0)
                                miso <= CPHA ? tx_shift[W-1] : load_word_c[W-1];
                            else
                                miso <= tx_shift[W-2];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-banged master, a tx source queue
// and an rx scoreboard, driven from a vector table plus overrun/abort/reset sequences.
module tb_spi_slave;
    localparam int HALF = 8;

    typedef struct {
        int              mode;
        int              nw;
        int              ntx;
        logic [2:0][7:0] tx;
        logic [2:0][7:0] mo;
        logic [2:0][7:0] mi;
        int              trdy;
        int              und;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mosi = 1'b0;
    logic       tx_tvalid = 1'b0;
    logic [7:0] tx_tdata = 8'h00;
    logic       rx_tready = 1'b1;

    logic       sck [4];
    logic       cs_n [4];
    logic       miso [4];
    logic       miso_oe [4];
    logic       tx_tready [4];
    logic [7:0] rx_tdata [4];
    logic       rx_tvalid [4];
    logic       tx_underrun [4];
    logic       rx_overrun [4];
    logic       frame_abort [4];

    logic [7:0] txq [$];
    logic [7:0] exp_rx [$];
    logic [7:0] mo_words [4];
    logic [7:0] rd_words [4];
    logic       oe_seen;

    int n_tests = 0, n_fail = 0;
    int tready_cnt = 0, underrun_cnt = 0, overrun_cnt = 0, abort_cnt = 0, rx_beats = 0;

    vec_t vecs [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .TRANSFER_WIDTH(8),
            .CPOL          (g >= 2),
            .CPHA          ((g % 2) == 1),
            .IDLE_WORD     (8'hFF)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .sck        (sck[g]),
            .cs_n       (cs_n[g]),
            .mosi       (mosi),
            .miso       (miso[g]),
            .miso_oe    (miso_oe[g]),
            .tx_tdata   (tx_tdata),
            .tx_tvalid  (tx_tvalid),
            .tx_tready  (tx_tready[g]),
            .rx_tdata   (rx_tdata[g]),
            .rx_tvalid  (rx_tvalid[g]),
            .rx_tready  (rx_tready),
            .tx_underrun(tx_underrun[g]),
            .rx_overrun (rx_overrun[g]),
            .frame_abort(frame_abort[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // tx source, pulse counters and rx scoreboard, all sampled on the falling clock edge
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (tx_tready[m]) begin
                    tready_cnt++;
                    if (txq.size() > 0) begin
                        void'(txq.pop_front());
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_tready: got pulse on dut %0d, expected none (no word offered)", m);
                    end
                end
                if (tx_underrun[m]) underrun_cnt++;
                if (rx_overrun[m])  overrun_cnt++;
                if (frame_abort[m]) abort_cnt++;
                if (rx_tvalid[m] && rx_tready) begin
                    rx_beats++;
                    if (exp_rx.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx beat: got %0h on dut %0d, expected no beat", rx_tdata[m], m);
                    end else begin
                        check($sformatf("rx word dut%0d", m), 32'(rx_tdata[m]), 32'(exp_rx.pop_front()));
                    end
                end
            end
            tx_tvalid = txq.size() > 0;
            tx_tdata  = tx_tvalid ? txq[0] : 8'h00;
        end
    end

    // Bit-banged SPI master; clocks nbits bits of mo_words and captures MISO into rd_words
    task automatic spi_frame(input int m, input int nbits, input bit end_cs);
        logic cpol, cpha;
        int   w, b;
        cpol = (m >= 2);
        cpha = ((m % 2) == 1);
        for (int i = 0; i < 4; i++) rd_words[i] = 8'h00;
        oe_seen = 1'b1;
        cs_n[m] = 1'b0;
        if (!cpha) mosi = mo_words[0][7];
        clk_wait(HALF);
        for (int i = 0; i < nbits; i++) begin
            w = i / 8;
            b = 7 - (i % 8);
            if (!cpha) begin
                rd_words[w][b] = miso[m];
                sck[m] = ~cpol;
                clk_wait(HALF);
                sck[m] = cpol;
                if (i + 1 < nbits) mosi = mo_words[(i + 1) / 8][7 - ((i + 1) % 8)];
                clk_wait(HALF);
            end else begin
                sck[m] = ~cpol;
                mosi   = mo_words[w][b];
                clk_wait(HALF);
                rd_words[w][b] = miso[m];
                sck[m] = cpol;
                clk_wait(HALF);
            end
            oe_seen &= miso_oe[m];
        end
        if (end_cs) begin
            cs_n[m] = 1'b1;
            clk_wait(HALF);
        end
    endtask

    function automatic vec_t mk(input int mode, input int nw, input int ntx,
                                input logic [23:0] tx, input logic [23:0] mo,
                                input logic [23:0] mi, input int trdy, input int und);
        vec_t v;
        v.mode = mode; v.nw = nw; v.ntx = ntx; v.trdy = trdy; v.und = und;
        for (int i = 0; i < 3; i++) begin
            v.tx[i] = tx[23 - 8*i -: 8];
            v.mo[i] = mo[23 - 8*i -: 8];
            v.mi[i] = mi[23 - 8*i -: 8];
        end
        return v;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int tr0, un0, bt0;
        for (int i = 0; i < v.ntx; i++) txq.push_back(v.tx[i]);
        for (int i = 0; i < v.nw; i++) begin
            mo_words[i] = v.mo[i];
            exp_rx.push_back(v.mo[i]);
        end
        clk_wait(4);
        tr0 = tready_cnt; un0 = underrun_cnt; bt0 = rx_beats;
        spi_frame(v.mode, v.nw * 8, 1'b1);
        clk_wait(4);
        for (int i = 0; i < v.nw; i++)
            check($sformatf("v%0d miso word%0d", id, i), 32'(rd_words[i]), 32'(v.mi[i]));
        check($sformatf("v%0d tx_tready pulses", id), 32'(tready_cnt - tr0), 32'(v.trdy));
        check($sformatf("v%0d tx_underrun pulses", id), 32'(underrun_cnt - un0), 32'(v.und));
        check($sformatf("v%0d rx beats", id), 32'(rx_beats - bt0), 32'(v.nw));
        check($sformatf("v%0d miso_oe in frame", id), 32'(oe_seen), 32'd1);
        check($sformatf("v%0d miso_oe after", id), 32'(miso_oe[v.mode]), 32'd0);
        check($sformatf("v%0d scoreboard drained", id), 32'(exp_rx.size()), 32'd0);
    endtask

    initial begin
        int ov0, bt0, ab0;
        for (int m = 0; m < 4; m++) begin
            sck[m]  = (m >= 2);
            cs_n[m] = 1'b1;
        end
        // Each frame also reloads once at its final word boundary, hence the extra underrun
        vecs[0] = mk(0, 1, 1, 24'hA50000, 24'h3C0000, 24'hA50000, 1, 1);
        vecs[1] = mk(1, 1, 1, 24'h810000, 24'h7E0000, 24'h810000, 1, 1);
        vecs[2] = mk(2, 1, 1, 24'h810000, 24'h7E0000, 24'h810000, 1, 1);
        vecs[3] = mk(3, 1, 1, 24'h810000, 24'h7E0000, 24'h810000, 1, 1);
        vecs[4] = mk(0, 3, 3, 24'h112233, 24'hC35A0F, 24'h112233, 3, 1);
        vecs[5] = mk(0, 2, 0, 24'h000000, 24'h123400, 24'hFFFF00, 0, 3);
        vecs[6] = mk(3, 3, 3, 24'h112233, 24'hA00BFE, 24'h112233, 3, 1);
        vecs[7] = mk(2, 1, 0, 24'h000000, 24'h550000, 24'hFF0000, 0, 2);

        clk_wait(5);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset outputs dut%0d", m),
                  {21'h0, miso[m], miso_oe[m], tx_tready[m], rx_tvalid[m], rx_tdata[m]}, 32'h0);
        end
        reset_n = 1'b1;
        clk_wait(5);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // rx backpressure across two words: second word dropped, first held
        rx_tready = 1'b0;
        mo_words[0] = 8'h01;
        mo_words[1] = 8'h02;
        exp_rx.push_back(8'h01);
        ov0 = overrun_cnt; bt0 = rx_beats;
        spi_frame(0, 16, 1'b1);
        clk_wait(4);
        check("overrun rx_tvalid held", 32'(rx_tvalid[0]), 32'd1);
        check("overrun rx_tdata held", 32'(rx_tdata[0]), 32'h01);
        check("overrun pulses", 32'(overrun_cnt - ov0), 32'd1);
        check("overrun no beat yet", 32'(rx_beats - bt0), 32'd0);
        rx_tready = 1'b1;
        clk_wait(4);
        check("overrun beat after ready", 32'(rx_beats - bt0), 32'd1);
        check("overrun rx_tvalid cleared", 32'(rx_tvalid[0]), 32'd0);
        check("overrun scoreboard drained", 32'(exp_rx.size()), 32'd0);

        // cs_n raised after 5 bits
        mo_words[0] = 8'hC5;
        ab0 = abort_cnt; bt0 = rx_beats;
        spi_frame(0, 5, 1'b1);
        clk_wait(4);
        check("abort pulses", 32'(abort_cnt - ab0), 32'd1);
        check("abort no rx beat", 32'(rx_beats - bt0), 32'd0);
        check("abort rx_tvalid", 32'(rx_tvalid[0]), 32'd0);
        check("abort miso_oe", 32'(miso_oe[0]), 32'd0);

        // reset_n asserted mid-word with cs_n still low
        mo_words[0] = 8'hE7;
        ab0 = abort_cnt;
        spi_frame(0, 5, 1'b0);
        check("pre-reset miso_oe", 32'(miso_oe[0]), 32'd1);
        reset_n = 1'b0;
        clk_wait(2);
        check("mid-word reset outputs",
              {21'h0, miso[0], miso_oe[0], tx_tready[0], rx_tvalid[0], rx_tdata[0]}, 32'h0);
        check("mid-word reset pulses",
              {29'h0, tx_underrun[0], rx_overrun[0], frame_abort[0]}, 32'h0);
        cs_n[0] = 1'b1;
        sck[0]  = 1'b0;
        mosi    = 1'b0;
        clk_wait(3);
        reset_n = 1'b1;
        clk_wait(6);
        check("reset no abort", 32'(abort_cnt - ab0), 32'd0);
        run_vec(8, mk(0, 1, 1, 24'h5A0000, 24'h960000, 24'h5A0000, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
